// File: rtl/vertex_dispatcher.sv
// vertex_dispatcher: streams whole faces from a show-ahead vertex FIFO to idle render cores
//   clk, rst            : clock, asynchronous active-high reset
//   ff_empty, ff_q      : FIFO status and head word (show-ahead)
//   ff_rdreq            : pop the head word this cycle
//   vertex_data/valid/last, target_core_id : shared broadcast bus
//   vertex_request      : per-core level request for a face
//   vertex_read_done    : per-core pulse, face consumed
//   core_busy           : registered busy mask
//   faces_sent          : completed face count (wraps)
module vertex_dispatcher #(
    parameter int NUM_CORES      = 87,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_FACE = 24,
    parameter int PRELOAD        = 1,
    localparam int ID_W          = $clog2(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ff_empty,
    input  logic [DATA_W-1:0]    ff_q,
    output logic                 ff_rdreq,
    output logic [DATA_W-1:0]    vertex_data,
    output logic [ID_W-1:0]      target_core_id,
    output logic                 vertex_valid,
    output logic                 vertex_last,
    input  logic [NUM_CORES-1:0] vertex_request,
    input  logic [NUM_CORES-1:0] vertex_read_done,
    output logic [NUM_CORES-1:0] core_busy,
    output logic [31:0]          faces_sent
);
    typedef enum logic {ARB, SEND} state_t;
    state_t               r_state, w_next;
    logic [ID_W-1:0]      r_cur_core, r_rr_ptr, w_pick;
    logic [ID_W:0]        w_off, w_sum;
    logic [7:0]           r_word_cnt;
    logic [NUM_CORES-1:0] r_busy, r_pending, w_elig, w_rot, w_grant_mask;
    logic [31:0]          r_faces;
    logic                 w_found, w_grant, w_send, w_last;

    assign w_elig = (vertex_request | r_pending) & ~r_busy;
    // Rotate so bit k is core (rr_ptr + k) mod NUM_CORES; lowest set bit is the winner.
    assign w_rot = NUM_CORES'({w_elig, w_elig} >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--)
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = (ID_W+1)'(k);
            end
    end

    assign w_sum        = {1'b0, r_rr_ptr} + w_off;
    assign w_pick       = (w_sum >= (ID_W+1)'(NUM_CORES)) ? ID_W'(w_sum - (ID_W+1)'(NUM_CORES)) : w_sum[ID_W-1:0];
    assign w_grant      = (r_state == ARB) && w_found;
    assign w_grant_mask = w_grant ? (NUM_CORES'(1) << w_pick) : '0;
    assign w_last       = r_word_cnt == 8'(WORDS_PER_FACE - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ARB;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == ARB) ? (w_found ? SEND : ARB) : ((w_send && w_last) ? ARB : SEND);
    end

    always_comb begin
        w_send         = (r_state == SEND) && !ff_empty;
        ff_rdreq       = w_send;
        vertex_valid   = w_send;
        vertex_last    = w_send && w_last;
        vertex_data    = w_send ? ff_q : '0;
        target_core_id = w_send ? r_cur_core : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_core <= '0;
            r_rr_ptr   <= '0;
            r_word_cnt <= '0;
            r_busy     <= '0;
            r_pending  <= {NUM_CORES{PRELOAD != 0}};
            r_faces    <= '0;
        end else begin
            if (w_grant) begin
                r_cur_core <= w_pick;
                r_rr_ptr   <= (w_pick == ID_W'(NUM_CORES - 1)) ? '0 : w_pick + 1'b1;
                r_word_cnt <= '0;
            end else if (w_send)
                r_word_cnt <= r_word_cnt + 8'd1;
            // Grant is ORed after the done-clear so a stray done for a freshly granted core is ignored.
            r_busy    <= (r_busy & ~vertex_read_done) | w_grant_mask;
            r_pending <= r_pending & ~w_grant_mask;
            if (w_send && w_last)
                r_faces <= r_faces + 32'd1;
        end
    end

    assign core_busy  = r_busy;
    assign faces_sent = r_faces;
endmodule
